// File: rtl/bus_collector8_if.sv
// Bus bundle for bus_collector8: eight request/data sources plus one valid/ready output.
// The slave modport is the collector's view; the master modport is the environment's view.
interface bus_collector8_if #(
    parameter int DATA_BITS = 8
);
    logic [7:0]           req;
    logic [DATA_BITS-1:0] in0;
    logic [DATA_BITS-1:0] in1;
    logic [DATA_BITS-1:0] in2;
    logic [DATA_BITS-1:0] in3;
    logic [DATA_BITS-1:0] in4;
    logic [DATA_BITS-1:0] in5;
    logic [DATA_BITS-1:0] in6;
    logic [DATA_BITS-1:0] in7;
    logic [7:0]           gnt;
    logic                 out_valid;
    logic [DATA_BITS-1:0] out_data;
    logic [2:0]           out_src;
    logic                 out_ready;

    modport slave (
        input  req, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
        output gnt, out_valid, out_data, out_src
    );

    modport master (
        output req, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
        input  gnt, out_valid, out_data, out_src
    );
endinterface

// File: rtl/bus_collector8.sv
// Round-robin merge of eight sources into a one-entry registered output buffer.
// Latency: a word granted at edge N is presented (out_valid=1) right after edge N.
// Backpressure: a full buffer with out_ready=0 blocks all grants; full with ready refills same cycle.
module bus_collector8 #(
    parameter int DATA_BITS = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    bus_collector8_if.slave bus
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [DATA_BITS-1:0] out_data_q, out_data_d;
    logic [2:0]           out_src_q, out_src_d;

    logic [DATA_BITS-1:0] in_arr [8];
    logic                 can_accept;
    logic                 found;
    logic                 grant;
    logic [2:0]           sel_idx;
    logic [7:0]           gnt_w;

    assign in_arr[0] = bus.in0;
    assign in_arr[1] = bus.in1;
    assign in_arr[2] = bus.in2;
    assign in_arr[3] = bus.in3;
    assign in_arr[4] = bus.in4;
    assign in_arr[5] = bus.in5;
    assign in_arr[6] = bus.in6;
    assign in_arr[7] = bus.in7;

    // Search starts at ptr and wraps modulo 8; the first hit wins.
    always_comb begin
        can_accept = (state_q == ST_EMPTY) || bus.out_ready;
        found      = 1'b0;
        sel_idx    = ptr_q;
        for (int i = 0; i < 8; i++) begin
            if (!found && bus.req[ptr_q + 3'(i)]) begin
                found   = 1'b1;
                sel_idx = ptr_q + 3'(i);
            end
        end
        // Gating with reset_n keeps gnt low while the flops are held in reset.
        grant = reset_n && can_accept && found;
        gnt_w = grant ? (8'b1 << sel_idx) : 8'b0;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        if (grant) begin
            out_data_d = in_arr[sel_idx];
            out_src_d  = sel_idx;
            ptr_d      = sel_idx + 3'd1;
            state_d    = ST_FULL;
        end else if (state_q == ST_FULL && bus.out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            ptr_q      <= 3'd0;
            out_data_q <= '0;
            out_src_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
        end
    end

    assign bus.gnt       = gnt_w;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
endmodule
